// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS core widths, fetch defaults and the fetch-queue entry type.
package mips_pkg;
  localparam int XLEN = 32;
  localparam int IMEM_AW = 32;
  localparam int IMEM_DW = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_3000;
  typedef struct packed {
    logic [IMEM_AW-1:0] pc;
    logic [IMEM_DW-1:0] instr;
  } ifq_entry_t;
endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: circular buffer of {pc, instr} with push, pop, full flush and keep-head-only flush.
//   clk, reset (async, active-low); i_push/i_pc/i_instr write the tail;
//   i_pop retires the head; i_flush empties; i_keep_head trims to the head entry;
//   o_pc/o_instr show the head; o_count is the number of stored entries.
module ifq_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [IMEM_AW-1:0]       i_pc,
  input  logic [IMEM_DW-1:0]       i_instr,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic                     i_keep_head,
  output logic [IMEM_AW-1:0]       o_pc,
  output logic [IMEM_DW-1:0]       o_instr,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  ifq_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr, w_wr;
  logic [CW-1:0] r_cnt, w_cnt;
  // Flush variants are applied before the push, so a push in a flush cycle lands in the emptied buffer.
  always_comb begin
    w_wr = i_flush ? r_rd : i_keep_head ? r_rd + AW'(1) : r_wr;
    w_cnt = i_flush ? '0 : i_keep_head ? CW'(1) : r_cnt - CW'(i_pop);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_rd <= '0;
      r_wr <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_rd <= r_rd + AW'(i_pop && !i_flush && !i_keep_head);
      r_wr <= w_wr + AW'(i_push);
      r_cnt <= w_cnt + CW'(i_push);
      if (i_push) r_mem[w_wr] <= '{pc: i_pc, instr: i_instr};
    end
  assign o_pc = r_mem[r_rd].pc;
  assign o_instr = r_mem[r_rd].instr;
  assign o_count = r_cnt;
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: in-order instruction prefetch queue feeding decode, with redirect and in-flight discard.
//   clk, reset (async, active-low); imem_req/imem_addr/imem_gnt request side;
//   imem_rvalid/imem_rdata in-order responses; stall/redirect/redirect_pc from decode;
//   instr_valid/instr/instr_pc present the oldest buffered instruction.
//   IFQ_DELAY_SLOT_EN: retain the sequentially next instruction across a redirect.
module ifetch_queue
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] W_DEPTH = CW'(DEPTH);
  logic r_run;
  logic [31:0] r_fetch_pc, w_fetch_nx;
  logic [CW-1:0] r_out, r_drop, w_cnt, w_out_nx, w_drop_nx;
  logic [31:0] r_rq_pc [DEPTH];
  logic [AW-1:0] r_rq_wr, r_rq_rd;
  logic w_gnt, w_stale, w_push, w_pop, w_flush, w_keep;
  // Credits are counted over buffered plus in-flight entries so every response has a slot.
  assign imem_req = r_run && (w_cnt + r_out < W_DEPTH);
  assign imem_addr = r_fetch_pc;
  assign instr_valid = w_cnt != '0;
  assign w_gnt = imem_req && imem_gnt;
  assign w_pop = instr_valid && !stall && !redirect;
  assign w_out_nx = r_out + CW'(w_gnt) - CW'(imem_rvalid);
`ifdef IFQ_DELAY_SLOT_EN
  logic r_ds_keep, r_pend, w_ds_keep_nx, w_pend_nx, w_ds_rsp;
  logic [31:0] r_pend_pc;
  // r_ds_keep: the next response is the delay slot and is kept before r_drop starts discarding.
  // r_pend: nothing was in flight at redirect, so fetch_pc is fetched once more before the target.
  always_comb begin
    w_stale = imem_rvalid && !r_ds_keep && r_drop != '0;
    w_keep = redirect && instr_valid && stall;
    w_flush = redirect && !w_keep;
    w_ds_rsp = redirect && !instr_valid && imem_rvalid && !w_stale;
    w_push = imem_rvalid && !w_stale && (!redirect || w_ds_rsp);
    w_pend_nx = redirect ? !instr_valid && !w_ds_rsp && w_out_nx == '0 : r_pend && !w_gnt;
    w_ds_keep_nx = redirect ? !instr_valid && !w_ds_rsp && w_out_nx != '0 : r_ds_keep && !imem_rvalid;
    w_drop_nx = !redirect ? r_drop - CW'(w_stale) : w_ds_keep_nx ? w_out_nx - CW'(1) : w_out_nx;
    w_fetch_nx = redirect ? (w_pend_nx ? r_fetch_pc : redirect_pc) :
                 !w_gnt ? r_fetch_pc : r_pend ? r_pend_pc : r_fetch_pc + 32'd4;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_ds_keep <= 1'b0;
      r_pend <= 1'b0;
      r_pend_pc <= '0;
    end else begin
      r_ds_keep <= w_ds_keep_nx;
      r_pend <= w_pend_nx;
      if (redirect) r_pend_pc <= redirect_pc;
    end
`else
  // Everything in flight at a redirect (including this cycle's grant) is stale; a same-cycle response is dropped outright.
  always_comb begin
    w_stale = imem_rvalid && r_drop != '0;
    w_keep = 1'b0;
    w_flush = redirect;
    w_push = imem_rvalid && !w_stale && !redirect;
    w_drop_nx = redirect ? w_out_nx : r_drop - CW'(w_stale);
    w_fetch_nx = redirect ? redirect_pc : w_gnt ? r_fetch_pc + 32'd4 : r_fetch_pc;
  end
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_run <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_out <= '0;
      r_drop <= '0;
      r_rq_wr <= '0;
      r_rq_rd <= '0;
    end else begin
      r_run <= 1'b1;
      r_fetch_pc <= w_fetch_nx;
      r_out <= w_out_nx;
      r_drop <= w_drop_nx;
      r_rq_wr <= r_rq_wr + AW'(w_gnt);
      r_rq_rd <= r_rq_rd + AW'(imem_rvalid);
    end
  // PC of each granted request, retired in response order to tag the returned word.
  always_ff @(posedge clk)
    if (w_gnt) r_rq_pc[r_rq_wr] <= r_fetch_pc;
  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_pc        (r_rq_pc[r_rq_rd]),
    .i_instr     (imem_rdata),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .i_keep_head (w_keep),
    .o_pc        (instr_pc),
    .o_instr     (instr),
    .o_count     (w_cnt)
  );
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: random and directed checks of ifetch_queue against a program-order reference model.
module tb_ifetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
`ifdef IFQ_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic imem_req, imem_gnt = 0, imem_rvalid = 0, stall = 0, redirect = 0, instr_valid;
  logic [31:0] imem_addr, imem_rdata = 0, redirect_pc = 0, instr, instr_pc;
  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t mq[$];
  int checks = 0, errs = 0, cyc = 0, consumed = 0, lat_lo = 1, lat_hi = 1;
  logic [31:0] exp_pc, exp_fetch, tgt;
  bit tgt_v, prev_r;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc)
  );

  function automatic logic [31:0] code(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    mq.delete();
    exp_pc = RST_PC;
    exp_fetch = RST_PC;
    tgt_v = 0;
    prev_r = 0;
    imem_gnt = 0; imem_rvalid = 0; stall = 0; redirect = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
  endtask

  // One clock: drive inputs after the edge, then advance the memory and program-order models.
  task automatic step(input logic g, input logic s, input logic r_req, input logic [31:0] rpc);
    logic rv, r, cons;
    @(posedge clk);
    #1;
    if (prev_r) chk("post_redirect_valid", instr_valid, 0);
    r = r_req && (!DS || instr_valid);
    rv = mq.size() != 0 && mq[0].due <= cyc;
    imem_gnt = g;
    imem_rvalid = rv;
    imem_rdata = rv ? code(mq[0].addr) : $urandom;
    stall = s;
    redirect = r;
    redirect_pc = rpc;
    #1;
    if (mq.size() >= DEPTH) chk("full_req", imem_req, 0);
    if (imem_req && g) begin
      chk("req_addr", imem_addr, exp_fetch);
      mq.push_back('{addr: imem_addr, due: cyc + $urandom_range(lat_lo, lat_hi)});
    end
    if (rv) void'(mq.pop_front());
    cons = instr_valid && !s && (!r || DS);
    if (cons) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr", instr, code(exp_pc));
      exp_pc = tgt_v ? tgt : exp_pc + 32'd4;
      tgt_v = 0;
      consumed++;
    end
    if (r) begin
      exp_fetch = rpc;
      if (DS && !cons) begin
        tgt = rpc;
        tgt_v = 1;
      end else begin
        exp_pc = rpc;
        tgt_v = 0;
      end
    end else if (imem_req && g) exp_fetch = exp_fetch + 32'd4;
    prev_r = r && !DS;
    cyc++;
  endtask

  initial begin
    int c0;
    logic [31:0] rpc;
    do_reset();
    // Zero-wait memory, no stall: one instruction per cycle once the pipe is primed.
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0, 0);
      if (i >= 3) chk("a_stream_valid", instr_valid, 1);
    end
    // Latency 3 with decode held: credits run out and requests stop, nothing lost afterwards.
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
    chk("b_req_stopped", imem_req, 0);
    chk("b_queue_full_valid", instr_valid, 1);
    c0 = consumed;
    for (int i = 0; i < 30; i++) step(1, 0, 0, 0);
    chk("b_progress", 32'(consumed > c0 + 10), 1);
    // Redirect with two requests in flight and an empty queue.
    do_reset();
    lat_lo = 6; lat_hi = 6;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("c_outstanding", mq.size(), 2);
    step(0, 1, 1, 32'h0000_3100);
    lat_lo = 1; lat_hi = 1;
    c0 = consumed;
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0);
    chk("c_progress", 32'(consumed > c0 + 5), 1);
    // Random traffic, with a reset asserted mid-way while the queue is full.
    lat_lo = 1; lat_hi = 4;
    c0 = consumed;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        repeat (8) step(1, 1, 0, 0);
        do_reset();
      end
      rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 : 32'h3000 + 32'($urandom_range(0, 255)) * 4;
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5, rpc);
    end
    chk("rand_progress", 32'(consumed > c0 + 300), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction-fetch stage with prefetch queue that sits directly upstream of the decode stage (F/D register) of the pipelined MIPS core. It issues in-order word requests to a variable-latency instruction memory, buffers returned instructions with their PCs, presents the oldest one to decode, and handles decode stalls and branch/jump redirects, including discard of in-flight responses.

## Interface
- DEPTH, 4, queue entries; also the cap on entries plus outstanding requests (power of two, 2..16)
- RESET_PC, 32'h0000_3000, first fetch address after reset
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request valid (driven from registers)
- imem_addr  out  32  word-aligned fetch address
- imem_gnt  in  1  request accepted this cycle when imem_req && imem_gnt
- imem_rvalid  in  1  one response, strictly in request order
- imem_rdata  in  32  instruction word for the response
- stall  in  1  decode hold; head is not consumed
- redirect  in  1  branch/jump taken in decode, one-cycle pulse
- redirect_pc  in  32  target address (word-aligned)
- instr_valid  out  1  head entry present
- instr  out  32  head instruction
- instr_pc  out  32  PC of head instruction

## Operation
- Consume: instr_valid && !stall && !redirect pops the head.
- Issue: imem_req = 1 when count + outstanding < DEPTH and no reset; on grant fetch_pc += 4, outstanding += 1.
- Response: imem_rvalid decrements outstanding; if drop_cnt > 0 it is discarded and drop_cnt -= 1, else pushed with its PC (a 2nd PC FIFO or a PC counter for responses).
- Redirect (without DELAY_SLOT_EN): flush queue; drop_cnt = outstanding after this cycle's grant/response; fetch_pc = redirect_pc.
- Simultaneous grant and redirect: the granted request is counted as outstanding and dropped.
- Simultaneous response and redirect: that response is discarded, not counted in drop_cnt.
- drop_cnt never exceeds DEPTH; outstanding never exceeds DEPTH; count + outstanding <= DEPTH always holds.
- Redirect during reset assertion is ignored.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, instr_valid 0, instr 0, instr_pc 0; queue, outstanding, drop_cnt cleared; first request in cycle after reset release.
- Response in cycle t -> instr_valid in cycle t+1 (registered queue); no combinational path from imem_rdata to instr.
- Redirect in cycle t -> imem_addr = redirect_pc (or delay-slot PC, see below) in t+1; instr_valid low in t+1 unless a retained entry exists.
- Full: no request while count + outstanding = DEPTH; a pop in cycle t frees a credit for a request in t+1.
- Empty with stall: instr_valid 0, nothing consumed.
- Pointers wrap modulo DEPTH; PC arithmetic wraps modulo 2^32.
- Reset asserted mid-operation: all state cleared immediately; late memory responses after release are the memory's responsibility (memory shares reset).

## Configuration
- IFQ_DELAY_SLOT_EN defined: redirect retains the sequentially next instruction (delay slot). Head present and not consumed -> keep head only. Head consumed this cycle -> keep nothing more. Queue empty, outstanding > 0 -> drop_cnt = outstanding - 1, first response kept. Queue empty, outstanding = 0 -> fetch fetch_pc once, then redirect_pc (one pending-target register).
- Undefined: redirect flushes everything; no delay-slot retention, pending-target register omitted.

## Structure
- Shared package mips_pkg: RESET_PC default, instruction/address width constants, IMEM request/response field widths.
- One sub-module ifq_fifo: circular buffer {pc, instr} with push, pop, flush, keep-head-only flush, count output.

## Test plan
- Reset release, zero-latency memory, stall 0 -> requests 0x3000,0x3004,0x3008..., instr_pc sequence identical, one instr per cycle.
- Memory latency 3, stall held 10 cycles -> at most 4 outstanding+queued, imem_req drops, no loss after release.
- Redirect to 0x3100 with 2 outstanding (flag off) -> both responses dropped, next instr_pc 0x3100.
- Flag on, redirect while queue empty and 2 outstanding -> first response (delay slot) delivered, second dropped, then 0x3100.
- Flag on, redirect with queue empty and 0 outstanding, fetch_pc 0x3010 -> requests 0x3010 then 0x3100.
- Reset asserted with full queue and outstanding requests -> all outputs to reset values same cycle, restart at 0x3000.
